// File: rtl/branch_resolve_driver.sv
// Trace-side initiator for the gshare predictor. It buffers resolved branches,
// requests a prediction for each one, sends the training update and keeps
// hit/miss statistics.
module branch_resolve_driver #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_taken,
  input  logic              in_last,
  output logic              pred_req,
  output logic [ADDR_W-1:0] pred_addr,
  input  logic              pred_valid,
  input  logic              pred_taken,
  output logic              upd_valid,
  output logic              upd_taken,
  output logic [CNT_W-1:0]  total_cnt,
  output logic [CNT_W-1:0]  correct_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              err_timeout,
  output logic              done
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [FCNT_W-1:0] FULL     = FCNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {IDLE, REQ, WAIT, UPD, DONE} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] mem_addr  [FIFO_DEPTH];
  logic              mem_taken [FIFO_DEPTH];
  logic              mem_last  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fcount;

  logic              entry_taken, entry_last, hit;
  logic [TMR_W-1:0]  timer;
  logic              push, pop;

  assign in_ready = (fcount != FULL);
  assign push     = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; pop only from IDLE, never from DONE
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (fcount != '0) begin
        pop        = 1'b1;
        state_next = REQ;
      end
      REQ:  state_next = WAIT;
      WAIT: if (pred_valid || (timer == TMR_LAST)) state_next = UPD;
      UPD:  state_next = entry_last ? DONE : IDLE;
      DONE: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Trace buffer storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= in_addr;
      mem_taken[wr_ptr] <= in_taken;
      mem_last[wr_ptr]  <= in_last;
    end
  end

  // Pointers, current entry, strobes and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fcount      <= '0;
      entry_taken <= 1'b0;
      entry_last  <= 1'b0;
      hit         <= 1'b0;
      timer       <= '0;
      pred_req    <= 1'b0;
      pred_addr   <= '0;
      upd_valid   <= 1'b0;
      upd_taken   <= 1'b0;
      total_cnt   <= '0;
      correct_cnt <= '0;
      miss_cnt    <= '0;
      err_timeout <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fcount <= fcount + FCNT_W'(1);
      else if (!push && pop) fcount <= fcount - FCNT_W'(1);

      if (pop) begin
        pred_addr   <= mem_addr[rd_ptr];
        entry_taken <= mem_taken[rd_ptr];
        entry_last  <= mem_last[rd_ptr];
      end

      pred_req  <= (state_next == REQ);
      upd_valid <= (state_next == UPD);
      upd_taken <= (state_next == UPD) ? entry_taken : 1'b0;
      done      <= done || (state_next == DONE);

      if (state == REQ) timer <= '0;
      else if (state == WAIT && !pred_valid) timer <= timer + TMR_W'(1);

      // A timed-out request always counts as a miss
      if (state == WAIT) begin
        if (pred_valid) begin
          hit <= (pred_taken == entry_taken);
        end else if (timer == TMR_LAST) begin
          hit         <= 1'b0;
          err_timeout <= 1'b1;
        end
      end

      if (state == UPD) begin
        if (total_cnt != CNT_MAX) total_cnt <= total_cnt + CNT_W'(1);
        if (hit) begin
          if (correct_cnt != CNT_MAX) correct_cnt <= correct_cnt + CNT_W'(1);
        end else begin
          if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_driver.sv
// Directed bench for branch_resolve_driver: a scripted predictor model answers
// requests, a monitor logs request/update traffic, each task checks its scenario.
module tb_branch_resolve_driver;

  localparam int unsigned AW = 11;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic          in_taken = 1'b0;
  logic          in_last = 1'b0;
  logic          pred_valid = 1'b0;
  logic          pred_taken = 1'b0;

  logic          in_ready, pred_req, upd_valid, upd_taken, err_timeout, done;
  logic [AW-1:0] pred_addr;
  logic [CW-1:0] total_cnt, correct_cnt, miss_cnt;

  logic          in_ready2, pred_req2, upd_valid2, upd_taken2, err_timeout2, done2;
  logic [AW-1:0] pred_addr2;
  logic [1:0]    total2, correct2, miss2;

  branch_resolve_driver #(.ADDR_W(AW), .FIFO_DEPTH(4), .CNT_W(CW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_taken(in_taken), .in_last(in_last),
    .pred_req(pred_req), .pred_addr(pred_addr), .pred_valid(pred_valid),
    .pred_taken(pred_taken), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .total_cnt(total_cnt), .correct_cnt(correct_cnt), .miss_cnt(miss_cnt),
    .err_timeout(err_timeout), .done(done)
  );

  branch_resolve_driver #(.ADDR_W(AW), .FIFO_DEPTH(4), .CNT_W(2), .TIMEOUT(8)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_addr(in_addr), .in_taken(in_taken), .in_last(in_last),
    .pred_req(pred_req2), .pred_addr(pred_addr2), .pred_valid(pred_valid),
    .pred_taken(pred_taken), .upd_valid(upd_valid2), .upd_taken(upd_taken2),
    .total_cnt(total2), .correct_cnt(correct2), .miss_cnt(miss2),
    .err_timeout(err_timeout2), .done(done2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Predictor model: answers one cycle after pred_req, or fires an injected pulse
  logic auto_en = 1'b0;
  logic auto_taken = 1'b0;
  logic pend = 1'b0;
  int   inject_cnt = 0;
  int   inject_seen = 0;
  always begin
    @(posedge clk);
    #1;
    pred_taken  = auto_taken;
    pred_valid  = pend || (inject_cnt != inject_seen);
    inject_seen = inject_cnt;
    pend        = pred_req && auto_en;
  end

  // Traffic monitor
  logic [AW-1:0] req_q[$];
  logic          upd_q[$];
  int            req_cyc = 0;
  int            upd_cyc = 0;
  always @(negedge clk) begin
    if (pred_req)  begin req_q.push_back(pred_addr); req_cyc = cyc; end
    if (upd_valid) begin upd_q.push_back(upd_taken); upd_cyc = cyc; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    auto_en  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    req_q.delete();
    upd_q.delete();
  endtask

  task automatic push(input logic [AW-1:0] a, input logic t, input logic l);
    int n = 0;
    in_addr  = a;
    in_taken = t;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_ready: in_ready stuck at %b for addr %0h", in_ready, a);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b, required 1 within %0d cycles", name, done, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, pred_req, upd_valid, upd_taken, err_timeout, done} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: {rdy,req,upd,updt,err,done}=%b, required 100000",
               {in_ready, pred_req, upd_valid, upd_taken, err_timeout, done});
    end
    checks++;
    if (pred_addr !== '0) begin
      errors++; $display("FAIL reset_pred_addr: got %0h, required 0", pred_addr);
    end
    checks++;
    if ({total_cnt, correct_cnt, miss_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_counters: total=%0d correct=%0d miss=%0d, required 0",
               total_cnt, correct_cnt, miss_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    auto_taken = 1'b1;
    auto_en    = 1'b1;
    push(11'h005, 1'b1, 1'b1);
    wait_done(30, "single");
    checks++;
    if (req_q.size() != 1 || req_q[0] !== 11'h005) begin
      errors++; $display("FAIL single_req: %0d requests, first addr %0h, required 1 at 005",
                         req_q.size(), (req_q.size() > 0) ? req_q[0] : 11'h7ff);
    end
    checks++;
    if (upd_q.size() != 1 || upd_q[0] !== 1'b1) begin
      errors++; $display("FAIL single_upd: %0d updates, required 1 with upd_taken=1", upd_q.size());
    end
    checks++;
    if (upd_cyc - req_cyc != 2) begin
      errors++; $display("FAIL single_latency: req->upd %0d cycles, required 2", upd_cyc - req_cyc);
    end
    checks++;
    if (total_cnt !== 16'd1 || correct_cnt !== 16'd1 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL single_counts: total=%0d correct=%0d miss=%0d, required 1/1/0",
                         total_cnt, correct_cnt, miss_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_addr [5];
    exp_addr = '{11'h010, 11'h021, 11'h032, 11'h043, 11'h054};
    do_reset();
    auto_en    = 1'b0;
    auto_taken = 1'b1;
    for (int i = 0; i < 5; i++) push(exp_addr[i], 1'b1, (i == 4));
    // First entry is stalled in WAIT, so the remaining four fill the buffer
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full: in_ready=%b, required 0", in_ready);
    end
    inject_cnt++;
    auto_en = 1'b1;
    wait_done(80, "b2b");
    checks++;
    if (req_q.size() != 5) begin
      errors++; $display("FAIL b2b_req_count: got %0d, required 5", req_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (req_q[i] !== exp_addr[i]) begin
          errors++; $display("FAIL b2b_order[%0d]: pred_addr %0h, required %0h", i, req_q[i], exp_addr[i]);
        end
      end
    end
    checks++;
    if (total_cnt !== 16'd5 || correct_cnt !== 16'd5 || miss_cnt !== 16'd0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL b2b_counts: total=%0d correct=%0d miss=%0d err=%b, required 5/5/0/0",
                         total_cnt, correct_cnt, miss_cnt, err_timeout);
    end
  endtask

  task automatic test_alternating();
    logic exp_t [4];
    exp_t = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    auto_taken = 1'b1;
    auto_en    = 1'b1;
    for (int i = 0; i < 4; i++) push(11'h100 + 11'(i), exp_t[i], (i == 3));
    wait_done(60, "alt");
    checks++;
    if (total_cnt !== 16'd4 || correct_cnt !== 16'd2 || miss_cnt !== 16'd2) begin
      errors++; $display("FAIL alt_counts: total=%0d correct=%0d miss=%0d, required 4/2/2",
                         total_cnt, correct_cnt, miss_cnt);
    end
    checks++;
    if (upd_q.size() != 4 || upd_q[0] !== 1'b1 || upd_q[1] !== 1'b0 ||
        upd_q[2] !== 1'b1 || upd_q[3] !== 1'b0) begin
      errors++; $display("FAIL alt_upd_taken: %0d updates, required sequence 1,0,1,0", upd_q.size());
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    auto_en = 1'b0;
    push(11'h2aa, 1'b1, 1'b0);
    while (!upd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (upd_q.size() != 1 || upd_cyc - req_cyc != 9) begin
      errors++; $display("FAIL timeout_len: %0d updates, req->upd %0d cycles, required 1 and 9",
                         upd_q.size(), upd_cyc - req_cyc);
    end
    inject_cnt++;
    repeat (4) @(negedge clk);
    checks++;
    if (err_timeout !== 1'b1 || total_cnt !== 16'd1 || miss_cnt !== 16'd1 || correct_cnt !== 16'd0) begin
      errors++; $display("FAIL timeout_counts: err=%b total=%0d correct=%0d miss=%0d, required 1/1/0/1",
                         err_timeout, total_cnt, correct_cnt, miss_cnt);
    end
    checks++;
    if (upd_q.size() != 1 || req_q.size() != 1) begin
      errors++; $display("FAIL timeout_late_pulse: %0d updates %0d requests, required 1/1",
                         upd_q.size(), req_q.size());
    end
    auto_taken = 1'b1;
    auto_en    = 1'b1;
    push(11'h2ab, 1'b0, 1'b1);
    wait_done(30, "timeout");
    checks++;
    if (total_cnt !== 16'd2 || miss_cnt !== 16'd2 || correct_cnt !== 16'd0 || upd_q.size() != 2) begin
      errors++; $display("FAIL timeout_after: total=%0d correct=%0d miss=%0d upds=%0d, required 2/0/2/2",
                         total_cnt, correct_cnt, miss_cnt, upd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto_en = 1'b0;
    auto_taken = 1'b1;
    push(11'h031, 1'b1, 1'b0);
    push(11'h032, 1'b1, 1'b0);
    push(11'h033, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || upd_valid !== 1'b0 || pred_req !== 1'b0 || err_timeout !== 1'b0 ||
        {total_cnt, correct_cnt, miss_cnt} !== '0) begin
      errors++; $display("FAIL midreset_state: rdy=%b upd=%b req=%b err=%b total=%0d, required 1/0/0/0/0",
                         in_ready, upd_valid, pred_req, err_timeout, total_cnt);
    end
    reset = 1'b0;
    req_q.delete();
    upd_q.delete();
    repeat (14) @(negedge clk);
    checks++;
    if (req_q.size() != 0 || upd_q.size() != 0 || done !== 1'b0) begin
      errors++; $display("FAIL midreset_flushed: %0d requests %0d updates done=%b, required 0/0/0",
                         req_q.size(), upd_q.size(), done);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    auto_taken = 1'b1;
    auto_en    = 1'b1;
    for (int i = 0; i < 5; i++) push(11'h040 + 11'(i), 1'b1, (i == 4));
    wait_done(80, "sat");
    checks++;
    if (total2 !== 2'd3 || correct2 !== 2'd3 || miss2 !== 2'd0) begin
      errors++; $display("FAIL sat_narrow: total=%0d correct=%0d miss=%0d, required 3/3/0",
                         total2, correct2, miss2);
    end
    checks++;
    if (total_cnt !== 16'd5 || correct_cnt !== 16'd5) begin
      errors++; $display("FAIL sat_wide: total=%0d correct=%0d, required 5/5", total_cnt, correct_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_alternating();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
